// File: rtl/mcpu_core_scoreboard.sv
// ---------------------------------------------------------------------------
// mcpu_core_scoreboard
//
// Tracks writes in flight to the 32 GPRs and to predicates 0..2. Each target
// has a CNT_W-bit counter. The counter goes up when decode issues a writer and
// goes down when the writer leaves the pipe. Decode stalls on any register
// whose scoreboard bit is set. Predicate 3 is the constant-true predicate, so
// it is never tracked.
//
// Ports
//   clkrst_core_clk       in   sole clock, rising edge
//   clkrst_core_rst_n     in   synchronous active-low reset
//   d2sb_issue            in   decode issued an instruction this cycle
//   d2sb_rd_num[4:0]      in   destination number (predicate in [1:0])
//   d2sb_rd_we            in   issued instruction writes a GPR
//   d2sb_pred_we          in   issued instruction writes a predicate
//   wb2sb_retire          in   one instruction leaves the pipe this cycle
//   wb2sb_rd_num[4:0]     in   destination of the retiring instruction
//   wb2sb_rd_we           in   retiring instruction had a GPR destination
//   wb2sb_pred_we         in   retiring instruction had a predicate destination
//   sb2d_reg_scoreboard   out  bit i set = GPR i has a pending write
//   sb2d_pred_scoreboard  out  bit p set = predicate p has a pending write
//   sb_idle               out  no pending write anywhere
//   sb_error              out  sticky counter overflow/underflow flag
// ---------------------------------------------------------------------------
module mcpu_core_scoreboard #(
    parameter int CNT_W = 2
) (
    input  logic        clkrst_core_clk,
    input  logic        clkrst_core_rst_n,
    input  logic        d2sb_issue,
    input  logic [4:0]  d2sb_rd_num,
    input  logic        d2sb_rd_we,
    input  logic        d2sb_pred_we,
    input  logic        wb2sb_retire,
    input  logic [4:0]  wb2sb_rd_num,
    input  logic        wb2sb_rd_we,
    input  logic        wb2sb_pred_we,
    output logic [31:0] sb2d_reg_scoreboard,
    output logic [2:0]  sb2d_pred_scoreboard,
    output logic        sb_idle,
    output logic        sb_error
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] gpr_cnt_q  [32];
    logic [CNT_W-1:0] gpr_cnt_d  [32];
    logic [CNT_W-1:0] pred_cnt_q [3];
    logic [CNT_W-1:0] pred_cnt_d [3];
    logic             err_q;
    logic             err_d;

    logic [31:0] gpr_inc;
    logic [31:0] gpr_dec;
    logic [2:0]  pred_inc;
    logic [2:0]  pred_dec;

    // When an increment and a decrement arrive together they cancel. A lone
    // increment saturates at the maximum. A lone decrement holds at zero.
    function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] cnt,
                                                  input logic inc,
                                                  input logic dec);
        logic [CNT_W-1:0] nxt;
        nxt = cnt;
        if (inc && !dec && (cnt != CNT_MAX)) begin
            nxt = cnt + 1'b1;
        end else if (dec && !inc && (cnt != '0)) begin
            nxt = cnt - 1'b1;
        end
        return nxt;
    endfunction

    // The counter overflowed or underflowed.
    function automatic logic cnt_err(input logic [CNT_W-1:0] cnt,
                                     input logic inc,
                                     input logic dec);
        return (inc && !dec && (cnt == CNT_MAX)) ||
               (dec && !inc && (cnt == '0));
    endfunction

    // Decode the issue and retire strobes into per-target increment and
    // decrement enables. Predicate 3 never matches because p only runs to 2.
    always_comb begin
        gpr_inc  = '0;
        gpr_dec  = '0;
        pred_inc = '0;
        pred_dec = '0;
        for (int i = 0; i < 32; i++) begin
            gpr_inc[i] = d2sb_issue   && d2sb_rd_we  && (d2sb_rd_num  == 5'(i));
            gpr_dec[i] = wb2sb_retire && wb2sb_rd_we && (wb2sb_rd_num == 5'(i));
        end
        for (int p = 0; p < 3; p++) begin
            pred_inc[p] = d2sb_issue   && d2sb_pred_we  && (d2sb_rd_num[1:0]  == 2'(p));
            pred_dec[p] = wb2sb_retire && wb2sb_pred_we && (wb2sb_rd_num[1:0] == 2'(p));
        end
    end

    always_comb begin
        err_d = err_q;
        for (int i = 0; i < 32; i++) begin
            gpr_cnt_d[i] = cnt_next(gpr_cnt_q[i], gpr_inc[i], gpr_dec[i]);
            err_d        = err_d | cnt_err(gpr_cnt_q[i], gpr_inc[i], gpr_dec[i]);
        end
        for (int p = 0; p < 3; p++) begin
            pred_cnt_d[p] = cnt_next(pred_cnt_q[p], pred_inc[p], pred_dec[p]);
            err_d         = err_d | cnt_err(pred_cnt_q[p], pred_inc[p], pred_dec[p]);
        end
    end

    always_ff @(posedge clkrst_core_clk) begin
        if (!clkrst_core_rst_n) begin
            for (int i = 0; i < 32; i++) begin
                gpr_cnt_q[i] <= '0;
            end
            for (int p = 0; p < 3; p++) begin
                pred_cnt_q[p] <= '0;
            end
            err_q <= 1'b0;
        end else begin
            for (int i = 0; i < 32; i++) begin
                gpr_cnt_q[i] <= gpr_cnt_d[i];
            end
            for (int p = 0; p < 3; p++) begin
                pred_cnt_q[p] <= pred_cnt_d[p];
            end
            err_q <= err_d;
        end
    end

    // The outputs come only from registered counters. A retire in the current
    // cycle does not clear a bit early, so decode may stall one extra cycle.
    always_comb begin
        for (int i = 0; i < 32; i++) begin
            sb2d_reg_scoreboard[i] = (gpr_cnt_q[i] != '0);
        end
        for (int p = 0; p < 3; p++) begin
            sb2d_pred_scoreboard[p] = (pred_cnt_q[p] != '0);
        end
    end

    assign sb_idle  = ~(|sb2d_reg_scoreboard) & ~(|sb2d_pred_scoreboard);
    assign sb_error = err_q;

endmodule

// File: tb/tb_mcpu_core_scoreboard.sv
module tb_mcpu_core_scoreboard;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        issue;
    logic [4:0]  rd_num;
    logic        rd_we;
    logic        pred_we;
    logic        retire;
    logic [4:0]  wb_rd_num;
    logic        wb_rd_we;
    logic        wb_pred_we;
    logic [31:0] reg_sb;
    logic [2:0]  pred_sb;
    logic        idle;
    logic        err;

    mcpu_core_scoreboard #(.CNT_W(2)) dut (
        .clkrst_core_clk      (clk),
        .clkrst_core_rst_n    (rst_n),
        .d2sb_issue           (issue),
        .d2sb_rd_num          (rd_num),
        .d2sb_rd_we           (rd_we),
        .d2sb_pred_we         (pred_we),
        .wb2sb_retire         (retire),
        .wb2sb_rd_num         (wb_rd_num),
        .wb2sb_rd_we          (wb_rd_we),
        .wb2sb_pred_we        (wb_pred_we),
        .sb2d_reg_scoreboard  (reg_sb),
        .sb2d_pred_scoreboard (pred_sb),
        .sb_idle              (idle),
        .sb_error             (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n;
        logic        iss;
        logic [4:0]  ird;
        logic        iwe;
        logic        ipwe;
        logic        ret;
        logic [4:0]  rrd;
        logic        rwe;
        logic        rpwe;
        logic [31:0] ereg;
        logic [2:0]  epred;
        logic        eidle;
        logic        eerr;
        logic        chk_err;
    } vec_t;

    typedef struct {
        logic [31:0] ereg;
        logic [2:0]  epred;
        logic        eidle;
        logic        eerr;
        logic        chk_err;
    } exp_t;

    vec_t vecs[$];
    exp_t expq[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic void add(input logic r, input logic iss, input logic [4:0] ird,
                                input logic iwe, input logic ipwe, input logic ret,
                                input logic [4:0] rrd, input logic rwe, input logic rpwe,
                                input logic [31:0] ereg, input logic [2:0] epred,
                                input logic eidle, input logic eerr);
        vec_t v;
        v.rst_n = r;   v.iss = iss; v.ird = ird; v.iwe = iwe; v.ipwe = ipwe;
        v.ret = ret;   v.rrd = rrd; v.rwe = rwe; v.rpwe = rpwe;
        v.ereg = ereg; v.epred = epred; v.eidle = eidle; v.eerr = eerr;
        v.chk_err = 1'b1;
        vecs.push_back(v);
    endfunction

    // Drive one cycle of inputs, queue what must show after the edge, then
    // sample one time unit after the edge and check it.
    task automatic step(input string name, input vec_t v);
        exp_t e;
        exp_t got;
        rst_n = v.rst_n; issue = v.iss; rd_num = v.ird; rd_we = v.iwe; pred_we = v.ipwe;
        retire = v.ret; wb_rd_num = v.rrd; wb_rd_we = v.rwe; wb_pred_we = v.rpwe;
        e.ereg = v.ereg; e.epred = v.epred; e.eidle = v.eidle; e.eerr = v.eerr;
        e.chk_err = v.chk_err;
        expq.push_back(e);
        @(posedge clk);
        #1;
        got = expq.pop_front();
        n_tests++;
        if (reg_sb !== got.ereg || pred_sb !== got.epred || idle !== got.eidle ||
            (got.chk_err && err !== got.eerr)) begin
            n_fail++;
            $display("FAIL %s: got reg=%08h pred=%03b idle=%0b err=%0b, want reg=%08h pred=%03b idle=%0b err=%0b",
                     name, reg_sb, pred_sb, idle, err, got.ereg, got.epred, got.eidle, got.eerr);
        end
    endtask

    int mg[32];
    int mp[3];
    logic merr;

    initial begin
        vec_t v;
        rst_n = 1'b0; issue = 1'b0; rd_num = '0; rd_we = 1'b0; pred_we = 1'b0;
        retire = 1'b0; wb_rd_num = '0; wb_rd_we = 1'b0; wb_pred_we = 1'b0;

        //   rst iss ird  iwe ipwe ret rrd  rwe rpwe  reg           pred   idle err
        add(0, 0, 5'd0, 0, 0,  0, 5'd0, 0, 0,  32'h0,        3'b000, 1, 0); // reset
        add(1, 1, 5'd5, 1, 0,  0, 5'd0, 0, 0,  32'h20,       3'b000, 0, 0); // issue r5
        add(1, 0, 5'd0, 0, 0,  0, 5'd0, 0, 0,  32'h20,       3'b000, 0, 0);
        add(1, 0, 5'd0, 0, 0,  0, 5'd0, 0, 0,  32'h20,       3'b000, 0, 0);
        add(1, 0, 5'd0, 0, 0,  1, 5'd5, 1, 0,  32'h0,        3'b000, 1, 0); // retire r5
        add(1, 1, 5'd7, 1, 0,  0, 5'd0, 0, 0,  32'h80,       3'b000, 0, 0); // WAW r7
        add(1, 1, 5'd7, 1, 0,  0, 5'd0, 0, 0,  32'h80,       3'b000, 0, 0);
        add(1, 0, 5'd0, 0, 0,  1, 5'd7, 1, 0,  32'h80,       3'b000, 0, 0);
        add(1, 0, 5'd0, 0, 0,  1, 5'd7, 1, 0,  32'h0,        3'b000, 1, 0);
        add(1, 1, 5'd2, 1, 0,  0, 5'd0, 0, 0,  32'h4,        3'b000, 0, 0); // r2=1
        add(1, 1, 5'd2, 1, 0,  1, 5'd2, 1, 0,  32'h4,        3'b000, 0, 0); // issue+retire r2
        add(1, 0, 5'd0, 0, 0,  1, 5'd2, 1, 0,  32'h0,        3'b000, 1, 0);
        add(1, 1, 5'd1, 0, 1,  0, 5'd0, 0, 0,  32'h0,        3'b010, 0, 0); // pred 1
        add(1, 1, 5'd3, 0, 1,  0, 5'd0, 0, 0,  32'h0,        3'b010, 0, 0); // pred 3 ignored
        add(1, 0, 5'd0, 0, 0,  1, 5'd3, 0, 1,  32'h0,        3'b010, 0, 0); // retire pred 3 ignored
        add(1, 0, 5'd0, 0, 0,  1, 5'd1, 0, 1,  32'h0,        3'b000, 1, 0);
        add(1, 1, 5'd6, 1, 1,  0, 5'd0, 0, 0,  32'h40,       3'b100, 0, 0); // r6 and pred 2
        add(1, 0, 5'd0, 0, 0,  1, 5'd6, 1, 1,  32'h0,        3'b000, 1, 0);
        add(1, 0, 5'd3, 1, 1,  0, 5'd3, 1, 1,  32'h0,        3'b000, 1, 0); // strobes low
        add(1, 1, 5'd9, 1, 0,  0, 5'd0, 0, 0,  32'h200,      3'b000, 0, 0); // r9 x4
        add(1, 1, 5'd9, 1, 0,  0, 5'd0, 0, 0,  32'h200,      3'b000, 0, 0);
        add(1, 1, 5'd9, 1, 0,  0, 5'd0, 0, 0,  32'h200,      3'b000, 0, 0);
        add(1, 1, 5'd9, 1, 0,  0, 5'd0, 0, 0,  32'h200,      3'b000, 0, 1); // saturate
        add(1, 0, 5'd0, 0, 0,  1, 5'd12, 1, 0, 32'h200,      3'b000, 0, 1); // underflow r12
        add(1, 0, 5'd0, 0, 0,  1, 5'd9, 1, 0,  32'h200,      3'b000, 0, 1);
        add(1, 0, 5'd0, 0, 0,  1, 5'd9, 1, 0,  32'h200,      3'b000, 0, 1);
        add(1, 0, 5'd0, 0, 0,  1, 5'd9, 1, 0,  32'h0,        3'b000, 1, 1); // held at 3
        add(0, 0, 5'd0, 0, 0,  0, 5'd0, 0, 0,  32'h0,        3'b000, 1, 0); // reset clears err
        add(1, 1, 5'd1, 1, 0,  0, 5'd0, 0, 0,  32'h2,        3'b000, 0, 0);
        add(1, 1, 5'd3, 1, 1,  0, 5'd0, 0, 0,  32'hA,        3'b000, 0, 0); // r3, pred 3 ignored
        add(1, 1, 5'd0, 0, 1,  0, 5'd0, 0, 0,  32'hA,        3'b001, 0, 0);
        add(0, 1, 5'd4, 1, 0,  0, 5'd0, 0, 0,  32'h0,        3'b000, 1, 0); // reset beats issue r4
        add(1, 0, 5'd0, 0, 0,  0, 5'd0, 0, 0,  32'h0,        3'b000, 1, 0);
        add(1, 0, 5'd0, 0, 0,  1, 5'd0, 1, 0,  32'h0,        3'b000, 1, 1); // underflow r0
        add(1, 1, 5'd0, 1, 0,  1, 5'd0, 1, 0,  32'h0,        3'b000, 1, 1); // cancel at zero
        add(1, 1, 5'd31, 1, 0, 0, 5'd0, 0, 0,  32'h80000000, 3'b000, 0, 1);
        add(0, 0, 5'd0, 0, 0,  0, 5'd0, 0, 0,  32'h0,        3'b000, 1, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            step($sformatf("vec%0d", i), vecs[i]);
        end

        // Random traffic on a few registers against a counter model.
        for (int i = 0; i < 32; i++) mg[i] = 0;
        for (int p = 0; p < 3; p++) mp[p] = 0;
        merr = 1'b0;
        for (int c = 0; c < 300; c++) begin
            v.rst_n = 1'b1;
            v.iss  = 1'($urandom_range(0, 1)); v.ird = 5'($urandom_range(0, 3));
            v.iwe  = 1'($urandom_range(0, 1)); v.ipwe = 1'($urandom_range(0, 1));
            v.ret  = 1'($urandom_range(0, 1)); v.rrd = 5'($urandom_range(0, 3));
            v.rwe  = 1'($urandom_range(0, 1)); v.rpwe = 1'($urandom_range(0, 1));
            for (int i = 0; i < 32; i++) begin
                bit inc, dec;
                inc = v.iss && v.iwe && (v.ird == 5'(i));
                dec = v.ret && v.rwe && (v.rrd == 5'(i));
                if (inc && !dec) begin
                    if (mg[i] == 3) merr = 1'b1; else mg[i]++;
                end else if (dec && !inc) begin
                    if (mg[i] == 0) merr = 1'b1; else mg[i]--;
                end
            end
            for (int p = 0; p < 3; p++) begin
                bit inc, dec;
                inc = v.iss && v.ipwe && (v.ird[1:0] == 2'(p));
                dec = v.ret && v.rpwe && (v.rrd[1:0] == 2'(p));
                if (inc && !dec) begin
                    if (mp[p] == 3) merr = 1'b1; else mp[p]++;
                end else if (dec && !inc) begin
                    if (mp[p] == 0) merr = 1'b1; else mp[p]--;
                end
            end
            for (int i = 0; i < 32; i++) v.ereg[i] = (mg[i] != 0);
            for (int p = 0; p < 3; p++) v.epred[p] = (mp[p] != 0);
            v.eidle   = (v.ereg == 32'h0) && (v.epred == 3'b000);
            v.eerr    = merr;
            v.chk_err = 1'b1;
            step($sformatf("rand%0d", c), v);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mcpu_core_scoreboard.md
MCPU_CORE_SCOREBOARD -- requirements
Module: MCPU_CORE_scoreboard

Interface
REQ-001 SHALL have parameter CNT_W, default 2, width of each per-register in-flight counter.
REQ-002 SHALL have port clkrst_core_clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port clkrst_core_rst_n  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port d2sb_issue  input  1  decode issued an instruction this cycle (valid, not stalled).
REQ-005 SHALL have port d2sb_rd_num  input  5  destination register number (pred number in bits [1:0]).
REQ-006 SHALL have port d2sb_rd_we  input  1  issued instruction writes GPR d2sb_rd_num.
REQ-007 SHALL have port d2sb_pred_we  input  1  issued instruction writes predicate d2sb_rd_num[1:0].
REQ-008 SHALL have port wb2sb_retire  input  1  one instruction leaves the pipe this cycle (written back or killed).
REQ-009 SHALL have port wb2sb_rd_num  input  5  destination of the retiring instruction.
REQ-010 SHALL have port wb2sb_rd_we  input  1  retiring instruction had a GPR destination.
REQ-011 SHALL have port wb2sb_pred_we  input  1  retiring instruction had a predicate destination.
REQ-012 SHALL have port sb2d_reg_scoreboard  output  32  bit i = GPR i has at least one pending write.
REQ-013 SHALL have port sb2d_pred_scoreboard  output  3  bit p = predicate p has at least one pending write.
REQ-014 SHALL have port sb_idle  output  1  no pending write on any GPR or predicate.
REQ-015 SHALL have port sb_error  output  1  sticky overflow/underflow flag.

Function
REQ-016 SHALL keep one CNT_W-bit counter per GPR (32) and per predicate 0..2 (3).
REQ-017 SHALL, on d2sb_issue with d2sb_rd_we, increment the counter of GPR d2sb_rd_num.
REQ-018 SHALL, on d2sb_issue with d2sb_pred_we and d2sb_rd_num[1:0] != 3, increment that predicate counter.
REQ-019 SHALL ignore predicate index 3 (constant-true predicate) for issue and retire, setting no state and no error.
REQ-020 SHALL, on wb2sb_retire with wb2sb_rd_we (resp. wb2sb_pred_we), decrement the matching GPR (resp. predicate) counter.
REQ-021 SHALL ignore rd_we/pred_we/rd_num on each port when that port's issue/retire strobe is low.
REQ-022 SHALL, when issue and retire hit the same counter in one cycle, leave it unchanged.
REQ-023 SHALL saturate at 2^CNT_W-1: further increment without a same-cycle decrement holds the value and sets sb_error.
REQ-024 SHALL hold at 0 on a decrement of a zero counter without a same-cycle increment, and set sb_error.
REQ-025 SHALL drive each scoreboard bit as (counter != 0) from registered state: issue in cycle N visible in N+1; retire in cycle N clears in N+1 if the counter reaches 0.
REQ-026 SHALL NOT bypass same-cycle retire into the scoreboard outputs (one-cycle conservative stall accepted).
REQ-027 SHALL drive sb_idle high iff all 35 counters are zero, from registered state.
REQ-028 SHALL keep sb_error set until reset once asserted.
REQ-029 SHALL allow d2sb_rd_we and d2sb_pred_we together (both counters increment); likewise for retire.

Reset
REQ-030 SHALL, when clkrst_core_rst_n is low at a clock edge, zero all counters and sb_error, overriding same-cycle issue/retire.
REQ-031 SHALL, in the cycle after reset, drive sb2d_reg_scoreboard=0, sb2d_pred_scoreboard=0, sb_idle=1, sb_error=0.
REQ-032 SHALL, on reset mid-operation, discard all pending state, with no error on later retires of pre-reset instructions' registers being required of the bench.

Verification
REQ-033 SHALL pass: issue rd_we r5 in cycle 0 -> sb2d_reg_scoreboard=0x00000020, sb_idle=0 from cycle 1; retire r5 in cycle 3 -> 0x0, sb_idle=1 from cycle 4.
REQ-034 SHALL pass: issue r7 twice (WAW), retire once -> bit 7 still set; second retire -> bit 7 clear next cycle, sb_error=0.
REQ-035 SHALL pass: counter r2=1, same-cycle issue r2 and retire r2 -> bit 2 stays set, counter stays 1; later single retire clears it.
REQ-036 SHALL pass: 4 issues to r9 with CNT_W=2 -> counter 3, sb_error=1 after 4th; retire of r12 at zero -> sb_error stays 1, bit 12 stays 0.
REQ-037 SHALL pass: issue pred_we rd_num=1 -> sb2d_pred_scoreboard=3'b010; issue pred_we rd_num=3 -> no change, sb_error=0.
REQ-038 SHALL pass: several registers pending, rst_n low one cycle concurrent with issue r4 -> all outputs at reset values (REQ-031) next cycle.
